// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the 4:1 mux round-robin arbiter.
//   arb_state_e  - arbiter FSM states (IDLE, BUSY, GAP)
//   NUM_REQ      - number of requesters / mux inputs
//   SEL_W        - width of the mux select {s1,s0}
//   hold_cnt_w() - width of the hold counter for a given MAX_HOLD (min 1)
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // The counter only has to reach MAX_HOLD-1, so clog2(MAX_HOLD) bits suffice.
  // MAX_HOLD=1 would give zero bits; keep one bit so the vector stays legal.
  function automatic int hold_cnt_w(input int max_hold);
    int w;
    w = $clog2(max_hold);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
//   req   [3:0] - current request vector
//   ptr   [1:0] - index of the last owner (lowest priority this round)
//   found       - at least one request is set
//   idx   [1:0] - first set request scanning upward from ptr+1, mod 4
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Offsets 1..NUM_REQ; the SEL_W-bit add wraps mod 4, so offset 4 lands on
  // ptr itself and the previous owner is considered last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 4:1 mux datapath.
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   req  [3:0] - level request per mux input Ii, held while using the mux
//   gnt  [3:0] - registered one-hot grant, zero when no owner
//   s1, s0     - registered mux select, change only on a grant edge
//   busy       - high while an owner holds the mux
//   preempt    - high during the GAP cycle that follows a forced release
//   dbg_state  - current FSM state
//
// Handshake: req/gnt are levels, not valid/ready. A requester raises req[i]
// and keeps it high while it owns the mux; gnt[i] high means the select
// already points at Ii. Dropping req[i] releases ownership at the next edge.
// A request is only seen when sampled at a grant decision; no memory exists.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               busy,
  output logic               preempt,
  output arb_state_e         dbg_state
);

  localparam int               CNT_W     = hold_cnt_w(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               pre_q, pre_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               do_grant;
  logic               forced;
  logic [NUM_REQ-1:0] owner_mask;
  logic               owner_req;
  logic               others_req;
  logic               hold_done;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // While BUSY the pointer is the owner, so it doubles as the owner index.
  assign owner_mask = NUM_REQ'(1) << ptr_q;
  assign owner_req  = req[ptr_q];
  assign others_req = |(req & ~owner_mask);
  assign hold_done  = (cnt_q == HOLD_LAST);

  // State register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(NUM_REQ - 1);
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      pre_q   <= pre_d;
    end
  end

  // Next-state logic. IDLE and GAP both grant via the rotated priority;
  // GAP only differs in that it exists to keep the select stable for a cycle.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    forced   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = BUSY;
          do_grant = 1'b1;
        end
      end
      BUSY: begin
        // Owner drop wins over hold expiry: that case is a voluntary release.
        if (!owner_req) begin
          state_d = GAP;
        end else if (hold_done && others_req) begin
          state_d = GAP;
          forced  = 1'b1;
        end
      end
      GAP: begin
        if (pick_found) begin
          state_d  = BUSY;
          do_grant = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    gnt_d  = '0;
    busy_d = (state_d == BUSY);
    pre_d  = forced;
    if (do_grant) begin
      ptr_d = pick_idx;
      sel_d = pick_idx;
      cnt_d = '0;
      gnt_d = NUM_REQ'(1) << pick_idx;
    end else if (state_q == BUSY && state_d == BUSY) begin
      gnt_d = gnt_q;
      cnt_d = hold_done ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign gnt       = gnt_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign busy      = busy_q;
  assign preempt   = pre_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int MAX_HOLD = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       s1, s0, busy, preempt;
  arb_state_e dbg_state;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .s1        (s1),
    .s0        (s0),
    .busy      (busy),
    .preempt   (preempt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];   // {gnt[3:0], sel[1:0], busy, preempt}

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner as an integer (-1 = none), plain cycle count since grant, last
  // owner index. IDLE and GAP look the same here: both just pick a winner.
  int m_owner, m_last, m_held, m_sel;
  bit m_pre;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_sel   = 0;
    m_pre   = 1'b0;
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r);
    int w;
    logic [3:0] others;
    logic [3:0] eg;
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      others = r & ~(4'(1 << m_owner));
      if (!r[m_owner]) m_owner = -1;
      else if (m_held >= MAX_HOLD && others != 4'b0) begin
        m_owner = -1;
        m_pre   = 1'b1;
      end else m_held++;
    end else begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 1;
        m_sel   = w;
      end
    end
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    exp_q.push_back({eg, 2'(m_sel), (m_owner >= 0), m_pre});
  endtask

  // ---------------- driver tasks ----------------
  task automatic compare_outputs(input string phase);
    logic [7:0] e;
    check({phase, "_qdepth"}, 8'(exp_q.size()), 8'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({phase, "_gnt"},     {4'b0, gnt},     {4'b0, e[7:4]});
      check({phase, "_sel"},     {6'b0, s1, s0},  {6'b0, e[3:2]});
      check({phase, "_busy"},    {7'b0, busy},    {7'b0, e[1]});
      check({phase, "_preempt"}, {7'b0, preempt}, {7'b0, e[0]});
    end
  endtask

  // Apply req at a falling edge, let the rising edge sample it, check at the
  // next falling edge.
  task automatic cycle(input logic [3:0] r, input string phase);
    req = r;
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    compare_outputs(phase);
  endtask

  task automatic repeat_cycle(input logic [3:0] r, input int n, input string phase);
    for (int i = 0; i < n; i++) cycle(r, phase);
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt",     {4'b0, gnt},     8'h00);
    check("rst_sel",     {6'b0, s1, s0},  8'h00);
    check("rst_busy",    {7'b0, busy},    8'h00);
    check("rst_preempt", {7'b0, preempt}, 8'h00);
    model_reset();
    exp_q.delete();
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r;
    model_reset();
    #1;
    check("por_gnt",  {4'b0, gnt},    8'h00);
    check("por_sel",  {6'b0, s1, s0}, 8'h00);
    check("por_busy", {7'b0, busy},   8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First grant from reset: pointer 3 means req[0] wins.
    repeat_cycle(4'b0001, 3, "first");
    repeat_cycle(4'b0000, 2, "first_idle");

    // Full contention: rotation with forced handovers every MAX_HOLD+1.
    do_reset();
    repeat_cycle(4'b1111, 5 * (MAX_HOLD + 1) + 3, "contend");

    // Sole requester keeps the grant with no preempt.
    do_reset();
    repeat_cycle(4'b0100, 20, "sole");

    // Voluntary release from owner 0 to requester 1.
    do_reset();
    repeat_cycle(4'b0011, 4, "vol");
    repeat_cycle(4'b0010, 5, "vol_next");

    // Async reset while requester 3 owns the mux, then pointer back to 3.
    do_reset();
    repeat_cycle(4'b1000, 3, "pre_rst");
    do_reset();
    repeat_cycle(4'b1001, 3, "post_rst");

    // Lost request: req[1] pulses while owner 0 is busy.
    do_reset();
    repeat_cycle(4'b0001, 3, "lost_own");
    repeat_cycle(4'b0011, 2, "lost_pulse");
    repeat_cycle(4'b0001, 1, "lost_own2");
    repeat_cycle(4'b0000, 4, "lost_idle");

    // Random phase: mostly-held levels with occasional toggles and clears.
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) r = 4'b0000;
      if ($urandom_range(0, 99) == 0) r = 4'($urandom_range(0, 15));
      cycle(r, "rand");
      if (i == 700) begin
        do_reset();
        r = 4'b0000;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 mux datapath among four requesters. It drives the mux select lines (s1, s0) and a one-hot grant vector. Ownership is held until the owner releases or a hold limit expires while others wait. One dead cycle is inserted between owners so the select never switches under an active grant.

## Interface

Parameters:
- MAX_HOLD, 8: maximum consecutive BUSY cycles for one owner while another request is pending; legal range 1..255.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request per requester; bit i maps to mux input Ii; level, held while using the mux.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- s1  output  1  mux select MSB, registered; connects to mux s1.
- s0  output  1  mux select LSB, registered; connects to mux s0.
- busy  output  1  high while an owner holds the mux (state BUSY).
- preempt  output  1  one-cycle pulse in the GAP cycle that follows a forced release.

## Operation

- Reset (async assert): gnt=0000, s1=0, s0=0, busy=0, preempt=0, state IDLE, last-owner pointer=3 (req[0] has top priority), hold counter=0.
- States: IDLE, BUSY, GAP.
- IDLE: if any req bit is set, go to BUSY with the winner granted. Otherwise stay.
- Winner selection: the first set req bit scanning upward from pointer+1, mod 4. On grant, pointer := winner, {s1,s0} := winner index, gnt := one-hot(winner), hold counter := 0.
- BUSY: busy=1, and the hold counter increments each cycle, saturating at MAX_HOLD-1.
  - If req[owner]=0, go to GAP (voluntary release).
  - Else, if counter==MAX_HOLD-1 and any other req bit is set, go to GAP with preempt=1 for the GAP cycle (forced release).
  - Else stay. A sole requester keeps the grant indefinitely with no preempt.
- GAP: gnt=0000, busy=0. {s1,s0} hold the previous owner's value.
  - If any req bit is set (including the previous owner's), grant the winner using the rotated priority and go to BUSY.
  - Else go to IDLE.
- Owner priority: the previous owner is lowest priority in GAP because the pointer equals it.
- Requests are level-sampled at the grant decision. A request that drops before being sampled is lost, with no memory.
- {s1,s0} change only on a grant edge. gnt is never non-zero for two different owners on consecutive cycles.

## Timing

- Request to grant: req rises before edge N in IDLE, so gnt is valid after edge N (1-cycle latency). {s1,s0} update on the same edge.
- Release: req[owner] falls before edge M. gnt=0 after edge M (GAP). Next grant after edge M+1.
- Forced release: the owner holds exactly MAX_HOLD cycles, then 1 GAP cycle. Handover period is MAX_HOLD+1 cycles.
- Simultaneous events:
  - Owner drop and hold expiry on the same edge is treated as a voluntary release; preempt=0.
  - A new request arriving on the expiry cycle counts as pending.
- Reset mid-operation: outputs go to reset values immediately without a clock edge. The first grant after release of rst_n follows IDLE rules with pointer=3.
- preempt is a registered output that is high only during the GAP cycle.

## Structure

- Package mux_arb_pkg holds:
  - the state enum (IDLE, BUSY, GAP),
  - NUM_REQ=4,
  - SEL_W=2,
  - the hold counter width function (clog2 of MAX_HOLD, minimum 1).
- Sub-module rr_pick: combinational; inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0]. The FSM, counter and output registers stay in mux_rr_arbiter.
- Top-level integration: gnt/s1/s0 feed the existing mux. Requester data feeds I0..I3.

## Test plan

- Reset and first grant: rst_n=0 gives gnt=0000, s1s0=00, busy=0. Release reset, then req=0001 gives gnt=0001, s1s0=00, busy=1 one cycle later.
- Full contention (MAX_HOLD=8, req=1111 held): grants run 0001, 0010, 0100, 1000, 0001, each for 8 cycles. Each transition has 1 GAP cycle with gnt=0000 and preempt=1. s1s0 steps 00, 01, 10, 11.
- Sole requester: req=0100 for 20 cycles gives gnt=0100 and s1s0=10 throughout, with preempt never asserted.
- Voluntary release: req=0011, owner 0 drops after 3 cycles. The sequence is 1 GAP cycle, then gnt=0010, s1s0=01, preempt=0.
- Async reset mid-grant: rst_n low between edges while gnt=1000 gives gnt=0000 and s1s0=00 immediately. After release with req=1001, the grant goes to 0001 (pointer back to 3).
- Lost request: req[1] pulses for 2 cycles while owner 0 is BUSY, and drops before GAP. Owner 0 releases, so GAP leads to IDLE with no grant to requester 1.
